// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: operand widths and the opcode map.
// The control unit imports this package so opcodes stay consistent.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    // Operation select driven by the control unit; 14..31 are reserved.
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SHR  = 5'd4,
        OP_SHRA = 5'd5,
        OP_SHL  = 5'd6,
        OP_ROR  = 5'd7,
        OP_ROL  = 5'd8,
        OP_NEG  = 5'd9,
        OP_NOT  = 5'd10,
        OP_MUL  = 5'd11,
        OP_DIV  = 5'd12,
        OP_REM  = 5'd13
    } op_e;

    // Selects the function inside the shifter sub-unit.
    typedef enum logic [2:0] {
        SH_SRL = 3'd0,
        SH_SRA = 3'd1,
        SH_SLL = 3'd2,
        SH_ROR = 3'd3,
        SH_ROL = 3'd4
    } shift_sel_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator for the ALU's shift opcodes.
// Only the 5-bit count is seen here; upper bits of B never reach this unit.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_sel_e         sel,
    output logic [DATA_W-1:0]  y
);

    // Complementary amount for rotates; a shift by the full width yields 0,
    // so a count of 0 leaves A unchanged without a special case.
    logic [SHAMT_W:0] inv_shamt;
    assign inv_shamt = 6'd32 - {1'b0, shamt};

    // Select the requested shift or rotate of A.
    always_comb begin
        // NOTE: y gets a default before the case so no path can infer a latch.
        y = a;
        case (sel)
            SH_SRL: y = a >> shamt;
            SH_SRA: y = $unsigned($signed(a) >>> shamt);
            SH_SLL: y = a << shamt;
            SH_ROR: y = (a >> shamt) | (a << inv_shamt);
            SH_ROL: y = (a << shamt) | (a >> inv_shamt);
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 32-bit single-cycle ALU with a registered result.
// Arithmetic, logic, multiply and divide are computed combinationally and
// captured on every rising clock; clear zeroes the result asynchronously.
module alu
    import alu_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] input_a,
    input  logic [DATA_W-1:0] input_b,
    input  logic [4:0]        opcode,
    output logic [DATA_W-1:0] ALU_result
);

    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [DATA_W-1:0]        product;
    logic [DATA_W-1:0]        quotient;
    logic [DATA_W-1:0]        remainder;
    logic                     div_zero;
    logic                     div_ovf;
    shift_sel_e               sh_sel;
    logic [DATA_W-1:0]        sh_y;
    logic [DATA_W-1:0]        next_result;

    assign sa        = $signed(input_a);
    assign sb        = $signed(input_b);
    assign product   = $unsigned(sa * sb);
    assign quotient  = $unsigned(sa / sb);
    assign remainder = $unsigned(sa % sb);
    assign div_zero  = (input_b == '0);
    assign div_ovf   = (input_a == 32'h8000_0000) && (input_b == 32'hFFFF_FFFF);

    // Map shift opcodes onto the shifter's function select.
    always_comb begin
        sh_sel = SH_SRL;
        case (opcode)
            OP_SHRA: sh_sel = SH_SRA;
            OP_SHL:  sh_sel = SH_SLL;
            OP_ROR:  sh_sel = SH_ROR;
            OP_ROL:  sh_sel = SH_ROL;
            default: sh_sel = SH_SRL;
        endcase
    end

    alu_shifter u_shifter (
        .a     (input_a),
        .shamt (input_b[SHAMT_W-1:0]),
        .sel   (sh_sel),
        .y     (sh_y)
    );

    // Compute the next result; reserved opcodes produce zero.
    always_comb begin
        next_result = '0;
        case (opcode)
            OP_ADD:  next_result = input_a + input_b;
            OP_SUB:  next_result = input_a - input_b;
            OP_AND:  next_result = input_a & input_b;
            OP_OR:   next_result = input_a | input_b;
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     next_result = sh_y;
            OP_NEG:  next_result = '0 - input_a;
            OP_NOT:  next_result = ~input_a;
            OP_MUL:  next_result = product;
            OP_DIV:  begin
                if (div_zero)     next_result = '1;
                else if (div_ovf) next_result = 32'h8000_0000;
                else              next_result = quotient;
            end
            OP_REM:  begin
                if (div_zero)     next_result = input_a;
                else if (div_ovf) next_result = '0;
                else              next_result = remainder;
            end
            default: next_result = '0;
        endcase
    end

    // Result register: loads every cycle, cleared asynchronously.
    always_ff @(posedge clock or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (clear) ALU_result <= '0;
        else       ALU_result <= next_result;
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the ALU: the driver pushes expected results computed
// by an arithmetic reference model; a monitor pops one per clock edge.
module tb_alu;

    logic        clock;
    logic        clear;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [4:0]  opcode;
    logic [31:0] ALU_result;

    typedef struct {
        logic [31:0] exp;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    failures = 0;

    alu dut (
        .clock      (clock),
        .clear      (clear),
        .input_a    (input_a),
        .input_b    (input_b),
        .opcode     (opcode),
        .ALU_result (ALU_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model written from the opcode rules with plain arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int     n  = int'(b % 32);
        logic [31:0] r = a;
        case (op)
            5'd0:  return 32'(sa + sb);
            5'd1:  return 32'(sa - sb);
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return 32'(longint'(a) / (longint'(1) << n));
            5'd5:  begin
                for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
                return r;
            end
            5'd6:  return 32'(longint'(a) * (longint'(1) << n));
            5'd7:  begin
                for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
                return r;
            end
            5'd8:  begin
                for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
                return r;
            end
            5'd9:  return 32'(0 - sa);
            5'd10: return 32'(64'hFFFF_FFFF - longint'(a));
            5'd11: return 32'(sa * sb);
            5'd12: return (sb == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            5'd13: return (sb == 0) ? a : 32'(sa % sb);
            default: return 32'h0;
        endcase
    endfunction

    // Drive one vector at the falling edge and record what must appear
    // after the next rising edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        item_t it;
        @(negedge clock);
        input_a = a;
        input_b = b;
        opcode  = op;
        it.exp = model(a, b, op);
        it.op  = op;
        it.a   = a;
        it.b   = b;
        q.push_back(it);
    endtask

    // Monitor: one result per rising edge while clear is low.
    initial begin
        item_t it;
        forever begin
            @(posedge clock);
            #1;
            if (!clear && q.size() > 0) begin
                it = q.pop_front();
                check($sformatf("op%0d a=%h b=%h", it.op, it.a, it.b), ALU_result, it.exp);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear   = 1'b1;
        input_a = 32'd5;
        input_b = 32'd9;
        opcode  = 5'd0;
        #1;
        check("reset_initial", ALU_result, 32'h0);
        repeat (3) begin
            @(negedge clock);
            check("reset_hold", ALU_result, 32'h0);
        end
        // Release clear together with the first vector.
        @(negedge clock);
        clear = 1'b0;
        q.push_back('{exp: model(32'd5, 32'd9, 5'd0), op: 5'd0, a: 32'd5, b: 32'd9});

        // Directed arithmetic/logic.
        apply(32'd2, 32'd3, 5'd0);
        apply(32'd2, 32'd3, 5'd1);
        apply(32'd12, 32'd17, 5'd2);
        apply(32'd17, 32'd20, 5'd3);
        // Shifts and rotates.
        apply(32'd17, 32'd17, 5'd4);
        apply(32'd17, 32'd17, 5'd6);
        apply(32'd17, 32'd17, 5'd7);
        apply(32'd17, 32'd17, 5'd8);
        apply(32'h8000_0000, 32'd4, 5'd5);
        apply(32'd17, 32'h21, 5'd6);
        apply(32'hDEAD_BEEF, 32'hFFFF_FFE0, 5'd7);
        // Unary ops with differing B.
        apply(32'd17, 32'd0, 5'd9);
        apply(32'd17, 32'hFFFF_1234, 5'd9);
        apply(32'd17, 32'd0, 5'd10);
        apply(32'd17, 32'h5555_AAAA, 5'd10);
        // Multiply/divide corners.
        apply(32'hFFFF_FFFA, 32'd7, 5'd11);
        apply(32'hFFFF_FFF9, 32'd2, 5'd12);
        apply(32'hFFFF_FFF9, 32'd2, 5'd13);
        apply(32'hFFFF_FFF9, 32'd0, 5'd12);
        apply(32'hFFFF_FFF9, 32'd0, 5'd13);
        apply(32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        apply(32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        // Reserved opcodes.
        apply(32'h1234_5678, 32'h9ABC_DEF0, 5'd15);
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);

        // Back-to-back opcode sweep with random operands.
        for (int op = 0; op < 14; op++)
            apply($urandom, $urandom, 5'(op));

        // Mid-stream clear: a pending vector is discarded and the output
        // drops immediately.
        apply(32'h0000_0F00, 32'h0000_00F0, 5'd3);
        @(negedge clock);
        input_a = 32'd100;
        input_b = 32'd1;
        opcode  = 5'd0;
        #2;
        clear = 1'b1;
        q.delete();
        #1;
        check("clear_async", ALU_result, 32'h0);
        repeat (3) begin
            @(negedge clock);
            check("clear_hold", ALU_result, 32'h0);
        end
        @(negedge clock);
        clear = 1'b0;
        q.push_back('{exp: model(32'd100, 32'd1, 5'd0), op: 5'd0, a: 32'd100, b: 32'd1});

        // Randomized traffic, biased toward small divisors and reserved codes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            logic [4:0]  op;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 13));
            apply(a, b, op);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

32-bit arithmetic/logic unit for the RISC datapath. It takes two 32-bit operands and a 5-bit operation code and returns a 32-bit result. The result is registered on the datapath clock and is written back to the register file or a datapath register. The control unit drives `opcode` directly from the decoded instruction.

## Interface
Parameters: none. Width is fixed at 32 bits and the opcode at 5 bits.

- `clock` input 1: datapath clock; all state updates on the rising edge.
- `clear` input 1: reset, asynchronous and active-high; forces the output register to 0.
- `input_a` input 32: operand A (first source register).
- `input_b` input 32: operand B (second source register or immediate); also the shift/rotate count.
- `opcode` input 5: operation select.
- `ALU_result` output 32: registered result.

## Operation
Opcode map:
- 0 add: A+B, modulo 2^32.
- 1 sub: A−B, modulo 2^32.
- 2 and: A & B.
- 3 or: A | B.
- 4 shr: logical right shift of A by B[4:0].
- 5 shra: arithmetic right shift of A by B[4:0]; the sign bit replicates.
- 6 shl: logical left shift of A by B[4:0].
- 7 ror: rotate A right by B[4:0].
- 8 rol: rotate A left by B[4:0].
- 9 neg: two's complement of A (0−A); B is ignored.
- 10 not: ~A; B is ignored.
- 11 mul: low 32 bits of the signed product A×B.
- 12 div: signed quotient A/B, truncated toward zero.
- 13 rem: signed remainder; the remainder takes the sign of A.
- 14–31: reserved; the result is 0x00000000.

Rules:
- Shift and rotate counts use only B[4:0]; B[31:5] is ignored. A count of 0 returns A unchanged.
- Divide by zero: div returns 0xFFFFFFFF and rem returns A. There is no trap.
- Signed overflow on 0x80000000 / −1: div returns 0x80000000 and rem returns 0.
- No flags are produced; carry and overflow are discarded.

## Timing
- The result is computed combinationally from `input_a`, `input_b` and `opcode`, then captured into `ALU_result` on each rising `clock`.
- Latency is 1 cycle: the result for inputs valid before edge N appears after edge N. There is no enable and no handshake; the register loads every cycle.
- `clear` asserted sets `ALU_result` to 0 immediately, regardless of `clock`. While `clear` is high the output stays 0. The first edge after `clear` deasserts loads the current result.
- Asserting `clear` mid-stream discards the pending result.
- mul/div/rem must close timing in the same single cycle as the other operations. A multi-cycle divider is out of scope for this block.

## Structure
- A shared package `alu_pkg` holds:
  - the opcode enumeration (`OP_ADD`=0 … `OP_REM`=13),
  - the width constant `DATA_W`=32,
  - the shift-count width constant 5.
- The control unit imports the same package.
- One sub-module is natural: `alu_shifter`, a combinational unit covering shr/shra/shl/ror/rol. Its inputs are A, B[4:0] and a 3-bit shift select.
- Everything else sits in one combinational case block followed by the output register.

## Test plan
- Reset: raise `clear` with nonzero inputs -> `ALU_result`=0 at once. Hold through several edges -> stays 0. Release -> result appears on the next edge.
- Arithmetic/logic: A=2, B=3, op0 -> 5. Op1 -> 0xFFFFFFFF. A=12, B=17, op2 -> 0. A=17, B=20, op3 -> 21. Each result appears one cycle after the inputs are applied.
- Shifts, A=17, B=17:
  - op4 -> 0.
  - op6 -> 0x00220000.
  - op7 -> 0x00088000.
  - op8 -> 0x00220000.
  - A=0x80000000, B=4, op5 -> 0xF8000000.
  - B=0x00000021, op6 -> A<<1, since only B[4:0] is used.
- Unary: A=17, op9 -> 0xFFFFFFEF. A=17, op10 -> 0xFFFFFFEE. Changing B has no effect on either.
- Mul/div:
  - A=−6, B=7, op11 -> 0xFFFFFFD6.
  - A=−7, B=2, op12 -> 0xFFFFFFFD; op13 -> 0xFFFFFFFF.
  - B=0: op12 -> 0xFFFFFFFF; op13 -> A.
  - A=0x80000000, B=−1, op12 -> 0x80000000.
- Reserved/back-to-back: op15 -> 0. Change opcode every cycle across 0–13 -> each result lands exactly one edge later, with no stale values.
